config_frame_loader: RTL and testbench

Bitstream-to-frame loader for the embedded FPGA fabric configuration plane. Accepts a 32-bit word stream, detects a sync word, assembles configuration frames and drives the frame data bus plus one-hot frame strobes into the fabric's configuration latches. The frame data bus feeds the latch D inputs; each frame strobe feeds the E inputs of one frame row. The block sits directly upstream of those latches.

---
 rtl/config_frame_loader.sv | 179 +++++++++++++++++
 tb/tb_config_frame_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_loader.sv
// Bitstream-to-frame loader: sync detect, frame assembly and one-hot latch strobes.
// Optional per-frame XOR check word enabled by `define CFG_FRAME_PARITY_EN.
module config_frame_loader #(
    parameter int FRAME_WORDS   = 2,
    parameter int NUM_FRAMES    = 20,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [31:0]               WriteData,
    input  logic                      WriteStrobe,
    output logic                      Ready,
    output logic                      Active,
    output logic [32*FRAME_WORDS-1:0] FrameData,
    output logic [NUM_FRAMES-1:0]     FrameStrobe,
    output logic                      Error
);

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'h0000_0000;
    localparam int          CW          = $clog2(FRAME_WORDS + 1);
    localparam int          SW          = $clog2(STROBE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
`ifdef CFG_FRAME_PARITY_EN
        S_CHECK,
`endif
        S_STROBE
    } state_t;

    state_t                    state_q;
    logic                      active_q;
    logic                      error_q;
    logic                      discard_q;
    logic [15:0]               index_q;
    logic [CW-1:0]             cnt_q;
    logic [SW-1:0]             scnt_q;
    logic [32*FRAME_WORDS-1:0] data_q;
    logic [NUM_FRAMES-1:0]     strobe_q;
    logic [NUM_FRAMES-1:0]     onehot_d;
    logic                      ready_d;
    logic                      accept_d;
`ifdef CFG_FRAME_PARITY_EN
    logic [31:0]               check_q;
    logic [31:0]               parity_d;
`endif

    always_comb begin
        ready_d = 1'b1;
        if (state_q == S_STROBE) ready_d = 1'b0;
`ifdef CFG_FRAME_PARITY_EN
        if (state_q == S_CHECK) ready_d = 1'b0;
`endif
    end

    // Ready is forced low while reset is held, independent of the state register.
    assign Ready    = ready_d & ~RST;
    assign accept_d = WriteStrobe & Ready;

    always_comb begin
        onehot_d = '0;
        for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
            if (index_q == 16'(i)) onehot_d[i] = 1'b1;
        end
    end

`ifdef CFG_FRAME_PARITY_EN
    always_comb begin
        parity_d = '0;
        for (int unsigned k = 0; k < FRAME_WORDS; k++) begin
            parity_d = parity_d ^ data_q[32*k +: 32];
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            active_q  <= 1'b0;
            error_q   <= 1'b0;
            discard_q <= 1'b0;
            index_q   <= '0;
            cnt_q     <= '0;
            scnt_q    <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
`ifdef CFG_FRAME_PARITY_EN
            check_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d && WriteData == SYNC_WORD) begin
                        state_q  <= S_HEADER;
                        active_q <= 1'b1;
                        error_q  <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (accept_d) begin
                        if (WriteData == DESYNC_WORD) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                        end else if (WriteData == SYNC_WORD) begin
                            error_q <= 1'b0;
                        end else if (WriteData[31]) begin
                            index_q   <= WriteData[15:0];
                            discard_q <= (32'(WriteData[15:0]) >= NUM_FRAMES);
                            if (32'(WriteData[15:0]) >= NUM_FRAMES) error_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_d) begin
                        if (32'(cnt_q) < FRAME_WORDS) data_q[32*int'(cnt_q) +: 32] <= WriteData;
`ifdef CFG_FRAME_PARITY_EN
                        else check_q <= WriteData;
`endif
                        if (cnt_q == CW'(FRAME_WORDS - 1)) begin
                            if (discard_q) begin
                                state_q <= S_HEADER;
                            end else begin
`ifdef CFG_FRAME_PARITY_EN
                                cnt_q <= cnt_q + 1'b1;
`else
                                state_q  <= S_STROBE;
                                strobe_q <= onehot_d;
                                scnt_q   <= '0;
`endif
                            end
                        end
`ifdef CFG_FRAME_PARITY_EN
                        else if (cnt_q == CW'(FRAME_WORDS)) begin
                            state_q <= S_CHECK;
                        end
`endif
                        else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef CFG_FRAME_PARITY_EN
                S_CHECK: begin
                    if (parity_d == check_q) begin
                        state_q  <= S_STROBE;
                        strobe_q <= onehot_d;
                        scnt_q   <= '0;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= S_HEADER;
                    end
                end
`endif
                S_STROBE: begin
                    if (scnt_q == SW'(STROBE_CYCLES - 1)) begin
                        strobe_q <= '0;
                        state_q  <= S_HEADER;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Active      = active_q;
    assign Error       = error_q;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: stimulus pushes expected strobes, a monitor checks them.
// Parity-specific vectors are included when CFG_FRAME_PARITY_EN is defined.
module tb_config_frame_loader;

    localparam int FW = 2;
    localparam int NF = 20;
    localparam int SC = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [31:0]      WriteData;
    logic             WriteStrobe;
    logic             Ready;
    logic             Active;
    logic [32*FW-1:0] FrameData;
    logic [NF-1:0]    FrameStrobe;
    logic             Error;

    typedef struct {
        logic [NF-1:0]    strobe;
        logic [32*FW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    config_frame_loader #(.FRAME_WORDS(FW), .NUM_FRAMES(NF), .STROBE_CYCLES(SC)) dut (
        .CLK(CLK), .RST(RST), .WriteData(WriteData), .WriteStrobe(WriteStrobe),
        .Ready(Ready), .Active(Active), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .Error(Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe rise pops one expected frame; length and Ready are checked too.
    logic [NF-1:0] prev_s = '0;
    int            len    = 0;
    exp_t          cur;
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            chk("strobe_onehot", 64'($onehot(FrameStrobe)), 64'd1);
            chk("ready_low_in_strobe", 64'(Ready), 64'd0);
            if (prev_s == '0) begin
                len = 1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got 0x%0h expected none at %0t", FrameStrobe, $time);
                end else begin
                    cur = exp_q.pop_front();
                    chk("strobe_pattern", 64'(FrameStrobe), 64'(cur.strobe));
                    chk("frame_data", 64'(FrameData), 64'(cur.data));
                end
            end else begin
                len++;
            end
        end else if (prev_s != '0 && !RST) begin
            chk("strobe_length", 64'(len), 64'(SC));
        end
        prev_s = FrameStrobe;
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        while (!Ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 64'(Ready), 64'd1);
        WriteData   = w;
        WriteStrobe = 1'b1;
        @(posedge CLK); #1;
        WriteStrobe = 1'b0;
    endtask

    task automatic send_frame(input int idx, input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        e.strobe = NF'(1) << idx;
        e.data   = {d1, d0};
        exp_q.push_back(e);
        send(32'h8000_0000 | 32'(idx));
        send(d0);
        send(d1);
`ifdef CFG_FRAME_PARITY_EN
        send(d0 ^ d1);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; WriteData = '0; WriteStrobe = 1'b0;
        idle(3);
        chk("rst_ready", 64'(Ready), 64'd0);
        chk("rst_active", 64'(Active), 64'd0);
        chk("rst_framedata", 64'(FrameData), 64'd0);
        chk("rst_strobe", 64'(FrameStrobe), 64'd0);
        chk("rst_error", 64'(Error), 64'd0);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", 64'(Ready), 64'd1);

        // Basic frame, then desync
        send(32'hFAB0_FAB1);
        chk("active_after_sync", 64'(Active), 64'd1);
        send_frame(3, 32'h1111_1111, 32'h2222_2222);
        chk("basic_error", 64'(Error), 64'd0);
        send(32'h0000_0000);
        chk("active_after_desync", 64'(Active), 64'd0);

        // Out-of-range index is consumed and discarded
        send(32'hFAB0_FAB1);
        send(32'h8000_0014);
        send(32'hDEAD_BEEF);
        send(32'hCAFE_F00D);
        idle(4);
        chk("badidx_error", 64'(Error), 64'd1);
        send_frame(1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        chk("error_sticky", 64'(Error), 64'd1);
        send(32'hFAB0_FAB1);
        chk("resync_clears_error", 64'(Error), 64'd0);

        // Non-frame header flags error and stays in HEADER
        send(32'h1234_5678);
        chk("junk_header_error", 64'(Error), 64'd1);
        send(32'hFAB0_FAB1);
        chk("resync_clears_error2", 64'(Error), 64'd0);

        // Write during STROBE is dropped
        send_frame(5, 32'h0123_4567, 32'h89AB_CDEF);
        chk("ready_low_for_drop", 64'(Ready), 64'd0);
        WriteData = 32'h8000_0000; WriteStrobe = 1'b1;
        @(posedge CLK); #1;
        WriteStrobe = 1'b0;
        send_frame(7, 32'hFFFF_0000, 32'h0000_FFFF);
        send_frame(19, 32'h1357_9BDF, 32'h2468_ACE0);
        chk("drop_error", 64'(Error), 64'd0);

`ifdef CFG_FRAME_PARITY_EN
        begin
            exp_t e;
            e.strobe = NF'(1) << 6;
            e.data   = {32'hFFFF_0000, 32'h0F0F_0F0F};
            exp_q.push_back(e);
            send(32'h8000_0006);
            send(32'h0F0F_0F0F);
            send(32'hFFFF_0000);
            send(32'hF0F0_0F0F);
            idle(4);
            chk("parity_ok_error", 64'(Error), 64'd0);
            send(32'h8000_0008);
            send(32'h0F0F_0F0F);
            send(32'hFFFF_0000);
            send(32'h0000_0000);
            idle(4);
            chk("parity_bad_error", 64'(Error), 64'd1);
            send(32'hFAB0_FAB1);
        end
`endif

        // Reset in the middle of a frame
        send(32'h8000_0002);
        send(32'h7777_7777);
        RST = 1'b1;
        #1;
        chk("midrst_strobe", 64'(FrameStrobe), 64'd0);
        chk("midrst_framedata", 64'(FrameData), 64'd0);
        chk("midrst_active", 64'(Active), 64'd0);
        chk("midrst_ready", 64'(Ready), 64'd0);
        idle(2);
        RST = 1'b0;
        #1;
        chk("midrst_ready_release", 64'(Ready), 64'd1);
        send(32'h8888_8888);
        send(32'h8000_0004);
        send(32'h1111_1111);
        send(32'h2222_2222);
        idle(5);
        chk("post_rst_active", 64'(Active), 64'd0);
        chk("post_rst_framedata", 64'(FrameData), 64'd0);

        idle(5);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_strobe", 64'(FrameStrobe), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
